// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU data load/store request bus.
// One word request at a time over req/ready, WAIT_CYCLES wait states,
// then a single-cycle ack carrying read data or an error flag.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | nothing outstanding, ready for a request
// S_WAIT | request latched, counting down wait states, not ready
// S_RESP | ack cycle; ready again so a new request can be accepted
module data_mem_responder #(
   parameter int ADDR_WIDTH  = 12,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        ready_o,
   output logic        ack_o,
   output logic [31:0] rdata_o,
   output logic        err_o,
   output logic        busy_o
);

   localparam int IDX_W       = ADDR_WIDTH - 2;
   localparam int DEPTH       = 1 << IDX_W;
   localparam int WAIT_LOAD_I = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
   localparam logic [3:0] WAIT_LOAD = WAIT_LOAD_I[3:0];

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t           state;
   logic [3:0]       wait_cnt;
   logic             lat_we;
   logic             lat_err;
   logic [IDX_W-1:0] lat_idx;
   logic [31:0]      lat_wdata;

   logic [31:0]      mem [DEPTH];

   logic             accept;
   logic             req_err;
   logic [IDX_W-1:0] req_idx;

   logic             go_resp;
   logic             acc_we;
   logic             acc_err;
   logic [IDX_W-1:0] acc_idx;
   logic [31:0]      acc_wdata;
   logic             wr_en;
   logic [31:0]      rd_word;

   assign accept  = req_i & ready_o;
   // misaligned, or any byte-address bit above the decoded window set
   assign req_err = (addr_i[1:0] != 2'b00) || ((addr_i >> ADDR_WIDTH) != 32'd0);
   assign req_idx = addr_i[ADDR_WIDTH-1:2];

   // Select the access that completes this cycle: with no wait states it is
   // the request being accepted right now, otherwise the latched one.
   always_comb begin
      go_resp   = 1'b0;
      acc_we    = lat_we;
      acc_err   = lat_err;
      acc_idx   = lat_idx;
      acc_wdata = lat_wdata;
      if (WAIT_CYCLES == 0) begin
         go_resp   = accept;
         acc_we    = we_i;
         acc_err   = req_err;
         acc_idx   = req_idx;
         acc_wdata = wdata_i;
      end else begin
         go_resp   = (state == S_WAIT) && (wait_cnt == 4'd0);
      end
   end

   // Reset suppresses the commit so an aborted store leaves the RAM untouched.
   assign wr_en   = go_resp & acc_we & ~acc_err & ~rst_i;
   assign rd_word = mem[acc_idx];

   // Word RAM write port; contents are deliberately not reset.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem[acc_idx] <= acc_wdata;
      end
   end

   // Handshake FSM with registered ready/busy/ack/err/rdata.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= S_IDLE;
         wait_cnt  <= 4'd0;
         lat_we    <= 1'b0;
         lat_err   <= 1'b0;
         lat_idx   <= '0;
         lat_wdata <= 32'd0;
         ready_o   <= 1'b1;
         ack_o     <= 1'b0;
         err_o     <= 1'b0;
         rdata_o   <= 32'd0;
         busy_o    <= 1'b0;
      end else begin
         ack_o   <= 1'b0;
         err_o   <= 1'b0;
         rdata_o <= 32'd0;

         case (state)
            S_IDLE, S_RESP: begin
               if (accept) begin
                  lat_we    <= we_i;
                  lat_err   <= req_err;
                  lat_idx   <= req_idx;
                  lat_wdata <= wdata_i;
                  busy_o    <= 1'b1;
                  if (WAIT_CYCLES == 0) begin
                     state   <= S_RESP;
                     ready_o <= 1'b1;
                  end else begin
                     state    <= S_WAIT;
                     wait_cnt <= WAIT_LOAD;
                     ready_o  <= 1'b0;
                  end
               end else begin
                  state   <= S_IDLE;
                  ready_o <= 1'b1;
                  busy_o  <= 1'b0;
               end
            end
            S_WAIT: begin
               if (wait_cnt == 4'd0) begin
                  state   <= S_RESP;
                  ready_o <= 1'b1;
                  busy_o  <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            default: begin
               state   <= S_IDLE;
               ready_o <= 1'b1;
               busy_o  <= 1'b0;
            end
         endcase

         // Completion: load data is captured at the same edge a store commits.
         if (go_resp) begin
            ack_o   <= 1'b1;
            err_o   <= acc_err;
            rdata_o <= (!acc_we && !acc_err) ? rd_word : 32'd0;
         end
      end
   end

endmodule
